// File: rtl/serial_conv_scheduler_pkg.sv
// serial_conv_scheduler_pkg: state encoding and default phase lengths for the conv scheduler.
package serial_conv_scheduler_pkg;
   localparam int DEF_LOAD_CYCLES  = 18;
   localparam int DEF_DRAIN_CYCLES = 2;
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_DRAIN = 3'd2,
      S_CAPT  = 3'd3,
      S_OUT   = 3'd4,
      S_FIN   = 3'd5
   } state_t;
endpackage

// File: rtl/serial_conv_scheduler_phase_cnt.sv
// serial_conv_scheduler_phase_cnt: loadable down-counter timing the LOAD and DRAIN phases.
module serial_conv_scheduler_phase_cnt #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_en,
   output logic         o_zero
);
   logic [W-1:0] r_cnt;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_cnt <= '0;
      else if (i_load) r_cnt <= i_load_val;
      else if (i_en && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
   end
   assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/serial_conv_scheduler.sv
// serial_conv_scheduler: runs loader+PE over a batch of conv windows, streaming one result per job.
// Optional SERIAL_SCHED_ABORT_EN adds an abort input that returns any active batch to IDLE.
module serial_conv_scheduler
   import serial_conv_scheduler_pkg::*;
#(
   parameter int ADDR_W       = 8,
   parameter int RES_W        = 16,
   parameter int LOAD_CYCLES  = DEF_LOAD_CYCLES,
   parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
   input  logic              clk,
   input  logic              rst,
`ifdef SERIAL_SCHED_ABORT_EN
   input  logic              abort,
`endif
   input  logic              start,
   input  logic [7:0]        num_jobs,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] addr_step,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              ld_en,
   output logic [ADDR_W-1:0] ld_feature_baseaddr,
   input  logic              ld_is_done,
   input  logic [RES_W-1:0]  pe_result,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [RES_W-1:0]  res_data,
   output logic [7:0]        res_idx
);
   localparam int CNT_W = $clog2(LOAD_CYCLES + 1);
   state_t            r_state, w_state_nxt;
   logic [7:0]        r_num, r_job;
   logic [ADDR_W-1:0] r_step, r_addr;
   logic [RES_W-1:0]  r_res;
   logic [7:0]        r_idx;
   logic              r_err;
   logic              w_zero, w_cnt_load, w_cnt_en, w_last_job, w_abort, w_hs;
   logic [CNT_W-1:0]  w_cnt_val;
`ifdef SERIAL_SCHED_ABORT_EN
   assign w_abort = abort && (r_state != S_IDLE);
`else
   assign w_abort = 1'b0;
`endif
   assign w_last_job = (r_job == r_num - 8'd1);
   assign w_hs       = (r_state == S_OUT) && res_ready && !w_abort;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else r_state <= w_state_nxt;
   end
   always_comb begin
      w_state_nxt = r_state;
      busy        = (r_state != S_IDLE);
      done        = (r_state == S_FIN);
      ld_en       = (r_state == S_LOAD);
      res_valid   = (r_state == S_OUT);
      case (r_state)
         S_IDLE:  if (start) w_state_nxt = (num_jobs == 8'd0) ? S_FIN : S_LOAD;
         S_LOAD:  if (w_zero) w_state_nxt = S_DRAIN;
         S_DRAIN: if (w_zero) w_state_nxt = S_CAPT;
         S_CAPT:  w_state_nxt = S_OUT;
         S_OUT:   if (res_ready) w_state_nxt = w_last_job ? S_FIN : S_LOAD;
         default: w_state_nxt = S_IDLE;
      endcase
      if (w_abort) w_state_nxt = S_IDLE;
   end
   // Counter reloads only on entry to a timed phase, so it reads zero on the phase's last cycle.
   assign w_cnt_load = (w_state_nxt != r_state) && (w_state_nxt == S_LOAD || w_state_nxt == S_DRAIN);
   assign w_cnt_val  = (w_state_nxt == S_LOAD) ? CNT_W'(LOAD_CYCLES - 1) : CNT_W'(DRAIN_CYCLES - 1);
   assign w_cnt_en   = (r_state == S_LOAD) || (r_state == S_DRAIN);
   serial_conv_scheduler_phase_cnt #(.W(CNT_W)) u_phase_cnt (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_cnt_load),
      .i_load_val (w_cnt_val),
      .i_en       (w_cnt_en),
      .o_zero     (w_zero)
   );
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_num  <= '0;
         r_job  <= '0;
         r_step <= '0;
         r_addr <= '0;
         r_res  <= '0;
         r_idx  <= '0;
         r_err  <= 1'b0;
      end else begin
         if (r_state == S_IDLE && start) begin
            r_num  <= num_jobs;
            r_step <= addr_step;
            r_job  <= '0;
            r_addr <= base_addr;
            r_err  <= 1'b0;
         end
         // Loader must flag done exactly on the final enable cycle; the count still drives the FSM.
         if (r_state == S_LOAD && ld_is_done != w_zero) r_err <= 1'b1;
         if (r_state == S_CAPT) begin
            r_res <= pe_result;
            r_idx <= r_job;
         end
         if (w_hs && !w_last_job) begin
            r_job  <= r_job + 8'd1;
            r_addr <= r_addr + r_step;
         end
      end
   end
   assign err                 = r_err;
   assign ld_feature_baseaddr = r_addr;
   assign res_data            = r_res;
   assign res_idx             = r_idx;
endmodule

// File: tb/tb_serial_conv_scheduler.sv
// tb_serial_conv_scheduler: directed scenario tests for serial_conv_scheduler with a small loader model.
module tb_serial_conv_scheduler;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  num_jobs = '0;
   logic [7:0]  base_addr = '0;
   logic [7:0]  addr_step = '0;
   logic        busy, done, err, ld_en, res_valid;
   logic [7:0]  ld_feature_baseaddr, res_idx;
   logic        ld_is_done;
   logic [15:0] pe_result = '0;
   logic        res_ready = 1'b0;
   logic [15:0] res_data;
   logic        inj = 1'b0;
   logic        abort = 1'b0;
   int          lc;
   int          checks = 0;
   int          errors = 0;

   serial_conv_scheduler dut (
      .clk                 (clk),
      .rst                 (rst),
`ifdef SERIAL_SCHED_ABORT_EN
      .abort               (abort),
`endif
      .start               (start),
      .num_jobs            (num_jobs),
      .base_addr           (base_addr),
      .addr_step           (addr_step),
      .busy                (busy),
      .done                (done),
      .err                 (err),
      .ld_en               (ld_en),
      .ld_feature_baseaddr (ld_feature_baseaddr),
      .ld_is_done          (ld_is_done),
      .pe_result           (pe_result),
      .res_valid           (res_valid),
      .res_ready           (res_ready),
      .res_data            (res_data),
      .res_idx             (res_idx)
   );

   always #5 clk = ~clk;

   // Loader stand-in: counts enable cycles, reports done on the 18th; inj adds a spurious done at 10.
   always @(posedge clk or negedge rst) begin
      if (!rst) lc <= 0;
      else if (ld_en) lc <= (lc == 17) ? 0 : lc + 1;
      else lc <= 0;
   end
   assign ld_is_done = ld_en && (lc == 17 || (inj && lc == 10));

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic start_batch(input logic [7:0] n, input logic [7:0] b, input logic [7:0] s);
      num_jobs  = n;
      base_addr = b;
      addr_step = s;
      start     = 1'b1;
      @(negedge clk);
      start     = 1'b0;
   endtask

   task automatic test_reset;
      checks++;
      if ({busy, done, err, ld_en, res_valid} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b want 00000", {busy, done, err, ld_en, res_valid});
      end
      checks++;
      if (ld_feature_baseaddr !== 8'h00 || res_data !== 16'h0 || res_idx !== 8'h00) begin
         errors++;
         $display("FAIL reset_data: addr %h data %h idx %h want 0", ld_feature_baseaddr, res_data, res_idx);
      end
   endtask

   task automatic test_single;
      int en_cnt = 0, addr_bad = 0, vcyc = 0, dcyc = 0;
      logic [15:0] d = '0;
      logic [7:0]  ix = '0;
      logic        e = 1'b1;
      res_ready = 1'b1;
      pe_result = 16'h1234;
      start_batch(8'd1, 8'h10, 8'h03);
      for (int c = 1; c <= 40; c++) begin
         if (ld_en) begin
            en_cnt++;
            if (ld_feature_baseaddr !== 8'h10) addr_bad++;
         end
         if (res_valid && vcyc == 0) begin
            vcyc = c;
            d    = res_data;
            ix   = res_idx;
         end
         if (done && dcyc == 0) begin
            dcyc = c;
            e    = err;
         end
         @(negedge clk);
      end
      checks++;
      if (en_cnt != 18) begin errors++; $display("FAIL single_ld_en_cycles: got %0d want 18", en_cnt); end
      checks++;
      if (addr_bad != 0) begin errors++; $display("FAIL single_addr: %0d cycles not 0x10 want 0", addr_bad); end
      checks++;
      if (vcyc != 22) begin errors++; $display("FAIL single_valid_cycle: got %0d want 22", vcyc); end
      checks++;
      if (d !== 16'h1234 || ix !== 8'h00) begin
         errors++;
         $display("FAIL single_result: data %h idx %h want 1234 00", d, ix);
      end
      checks++;
      if (dcyc != 23 || e !== 1'b0) begin
         errors++;
         $display("FAIL single_done: cycle %0d err %b want 23 0", dcyc, e);
      end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: busy %b want 0", busy); end
   endtask

   task automatic test_multi;
      logic [7:0]  ea;
      logic [15:0] ed;
      res_ready = 1'b1;
      start_batch(8'd4, 8'hFE, 8'h01);
      for (int j = 0; j < 4; j++) begin
         ea = 8'hFE + 8'(j);
         ed = 16'hA000 + 16'(j);
         for (int c = 0; c < 40 && !ld_en; c++) @(negedge clk);
         checks++;
         if (ld_en !== 1'b1 || ld_feature_baseaddr !== ea) begin
            errors++;
            $display("FAIL multi_addr%0d: ld_en %b addr %h want 1 %h", j, ld_en, ld_feature_baseaddr, ea);
         end
         pe_result = ed;
         for (int c = 0; c < 40 && !res_valid; c++) @(negedge clk);
         checks++;
         if (res_valid !== 1'b1 || res_data !== ed || res_idx !== 8'(j)) begin
            errors++;
            $display("FAIL multi_res%0d: valid %b data %h idx %0d want 1 %h %0d", j, res_valid, res_data, res_idx, ed, j);
         end
         @(negedge clk);
      end
      checks++;
      if (done !== 1'b1) begin errors++; $display("FAIL multi_done: got %b want 1", done); end
      @(negedge clk);
   endtask

   task automatic test_backpressure;
      res_ready = 1'b0;
      pe_result = 16'h5555;
      start_batch(8'd2, 8'h20, 8'h04);
      for (int c = 0; c < 40 && !res_valid; c++) @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || res_data !== 16'h5555) begin
         errors++;
         $display("FAIL bp_first: valid %b data %h want 1 5555", res_valid, res_data);
      end
      pe_result = 16'h7777;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checks++;
         if (res_valid !== 1'b1 || res_data !== 16'h5555 || res_idx !== 8'h00 || ld_en !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold%0d: valid %b data %h idx %h ld_en %b want 1 5555 00 0", k, res_valid, res_data, res_idx, ld_en);
         end
      end
      res_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (ld_en !== 1'b1 || ld_feature_baseaddr !== 8'h24) begin
         errors++;
         $display("FAIL bp_next_load: ld_en %b addr %h want 1 24", ld_en, ld_feature_baseaddr);
      end
      for (int c = 0; c < 40 && !res_valid; c++) @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || res_data !== 16'h7777 || res_idx !== 8'h01) begin
         errors++;
         $display("FAIL bp_second: valid %b data %h idx %h want 1 7777 01", res_valid, res_data, res_idx);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b1) begin errors++; $display("FAIL bp_done: got %b want 1", done); end
      @(negedge clk);
   endtask

   task automatic test_err;
      res_ready = 1'b1;
      inj = 1'b1;
      start_batch(8'd1, 8'h40, 8'h00);
      for (int c = 0; c < 40 && !done; c++) @(negedge clk);
      checks++;
      if (done !== 1'b1 || err !== 1'b1) begin
         errors++;
         $display("FAIL err_set: done %b err %b want 1 1", done, err);
      end
      inj = 1'b0;
      @(negedge clk);
      checks++;
      if (err !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL err_sticky: err %b busy %b want 1 0", err, busy);
      end
      start_batch(8'd1, 8'h40, 8'h00);
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b want 0", err); end
      for (int c = 0; c < 40 && !done; c++) @(negedge clk);
      checks++;
      if (done !== 1'b1 || err !== 1'b0) begin
         errors++;
         $display("FAIL err_clean_run: done %b err %b want 1 0", done, err);
      end
      @(negedge clk);
   endtask

   task automatic test_zero_and_busy_start;
      int nres = 0, addr_bad = 0;
      logic seen = 1'b0;
      res_ready = 1'b1;
      start_batch(8'd0, 8'h55, 8'h01);
      checks++;
      if (done !== 1'b1 || busy !== 1'b1 || ld_en !== 1'b0) begin
         errors++;
         $display("FAIL zero_done: done %b busy %b ld_en %b want 1 1 0", done, busy, ld_en);
      end
      start_batch(8'd5, 8'h66, 8'h01);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL start_in_fin: busy %b done %b want 0 0", busy, done);
      end
      start_batch(8'd1, 8'h30, 8'h10);
      repeat (4) @(negedge clk);
      start_batch(8'd3, 8'h99, 8'h01);
      for (int c = 0; c < 60 && !seen; c++) begin
         if (res_valid) nres++;
         if (ld_en && ld_feature_baseaddr !== 8'h30) addr_bad++;
         if (done) seen = 1'b1;
         else @(negedge clk);
      end
      checks++;
      if (!seen || nres != 1 || addr_bad != 0) begin
         errors++;
         $display("FAIL start_while_busy: done_seen %b results %0d bad_addr %0d want 1 1 0", seen, nres, addr_bad);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid;
      start_batch(8'd2, 8'h77, 8'h01);
      repeat (5) @(negedge clk);
      checks++;
      if (ld_en !== 1'b1) begin errors++; $display("FAIL rstmid_pre: ld_en %b want 1", ld_en); end
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({busy, done, err, ld_en, res_valid} !== 5'b0 || ld_feature_baseaddr !== 8'h00) begin
         errors++;
         $display("FAIL rstmid_async: ctrl %b addr %h want 00000 00", {busy, done, err, ld_en, res_valid}, ld_feature_baseaddr);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_after: busy %b done %b want 0 0", busy, done);
      end
   endtask

`ifdef SERIAL_SCHED_ABORT_EN
   task automatic test_abort;
      logic seen = 1'b0;
      res_ready = 1'b1;
      start_batch(8'd1, 8'h11, 8'h00);
      for (int c = 0; c < 40 && ld_en; c++) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checks++;
      if (busy !== 1'b0 || res_valid !== 1'b0 || ld_en !== 1'b0) begin
         errors++;
         $display("FAIL abort_idle: busy %b valid %b ld_en %b want 0 0 0", busy, res_valid, ld_en);
      end
      for (int c = 0; c < 25; c++) begin
         if (done) seen = 1'b1;
         @(negedge clk);
      end
      checks++;
      if (seen) begin errors++; $display("FAIL abort_no_done: done seen 1 want 0"); end
   endtask
`endif

   initial begin
      repeat (2) @(negedge clk);
      test_reset;
      rst = 1'b1;
      @(negedge clk);
      test_single;
      test_multi;
      test_backpressure;
      test_err;
      test_zero_and_busy_start;
      test_reset_mid;
`ifdef SERIAL_SCHED_ABORT_EN
      test_abort;
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
